// File: rtl/edgedet_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// Holds the per-channel FSM state encoding and the default configuration
// constants used by edgedet_multi and edgedet_chan.
package edgedet_pkg;

  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_RISE = 2'd1,
    ST_ONE  = 2'd2,
    ST_FALL = 2'd3
  } edge_state_t;

  localparam int CH_DEF          = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 4;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/edgedet_chan.sv
// One edge-detector channel: synchroniser, glitch filter, Moore edge FSM,
// sticky pending flag and (with EDGEDET_CNT_EN) a saturating edge counter.
// Latency: level change to tick is SYNC_STAGES + FILT_CYCLES + 1 cycles.
// Backpressure: none; events are recorded in the sticky pending flag.
// Ports: clk, reset (async, active-high), async_level (raw input),
//   rise_en/fall_en (tick enables), clear (pending/counter clear),
//   filt_level, tick, pending, count (EDGEDET_CNT_EN only).
module edgedet_chan
  import edgedet_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             async_level,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             clear,
  output logic             filt_level,
`ifdef EDGEDET_CNT_EN
  output logic [CNT_W-1:0] count,
`endif
  output logic             tick,
  output logic             pending
);

  localparam int FW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [FW-1:0]          filt_cnt;
  edge_state_t            state;
  edge_state_t            state_nxt;

  // Synchroniser chain; s is the last stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], async_level};
  end
  assign s = sync[SYNC_STAGES-1];

  // Glitch filter: the filtered level only follows s after FILT_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt   <= '0;
      filt_level <= 1'b0;
    end else if (s != filt_level) begin
      if (filt_cnt == FW'(FILT_CYCLES - 1)) begin
        filt_cnt   <= '0;
        filt_level <= ~filt_level;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Edge FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_ZERO;
    else       state <= state_nxt;
  end

  // Edge FSM: next state
  always_comb begin
    state_nxt = ST_ZERO;
    case (state)
      ST_ZERO: state_nxt = filt_level ? ST_RISE : ST_ZERO;
      ST_RISE: state_nxt = filt_level ? ST_ONE  : ST_FALL;
      ST_ONE:  state_nxt = filt_level ? ST_ONE  : ST_FALL;
      ST_FALL: state_nxt = filt_level ? ST_RISE : ST_ZERO;
      default: state_nxt = ST_ZERO;
    endcase
  end

  // Edge FSM: Moore output; enables gate the tick but never the state.
  always_comb begin
    tick = 1'b0;
    case (state)
      ST_RISE: tick = rise_en;
      ST_FALL: tick = fall_en;
      default: tick = 1'b0;
    endcase
  end

  // Sticky flag: a tick in the same cycle as clear still sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pending <= 1'b0;
    else if (tick) pending <= 1'b1;
    else if (clear) pending <= 1'b0;
  end

`ifdef EDGEDET_CNT_EN
  // Saturating edge counter; clear with a coincident tick restarts at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (clear)                 count <= {{(CNT_W-1){1'b0}}, tick};
    else if (tick && (count != '1)) count <= count + 1'b1;
  end
`endif

endmodule

// File: rtl/edgedet_multi.sv
// Multi-channel edge detector for GPIO/button events with sticky flags and irq.
// Latency: level change to o_tick is SYNC_STAGES + FILT_CYCLES + 1 cycles,
// o_pending one cycle later, o_irq two. Backpressure: none (sticky flags).
// Ports: clk, reset (async, active-high), i_level, i_rise_en, i_fall_en,
//   i_clear, o_level, o_tick, o_pending, o_irq, o_count.
// Macro EDGEDET_CNT_EN adds per-channel saturating edge counters on o_count.
module edgedet_multi
  import edgedet_pkg::*;
#(
  parameter int CH          = CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CH-1:0]       i_level,
  input  logic [CH-1:0]       i_rise_en,
  input  logic [CH-1:0]       i_fall_en,
  input  logic [CH-1:0]       i_clear,
  output logic [CH-1:0]       o_level,
  output logic [CH-1:0]       o_tick,
  output logic [CH-1:0]       o_pending,
`ifdef EDGEDET_CNT_EN
  output logic [CH*CNT_W-1:0] o_count,
`endif
  output logic                o_irq
);

  // Elaboration-time parameter sanity checks.
  if (CH < 1)          begin : g_bad_ch   $error("CH must be >= 1");          end
  if (SYNC_STAGES < 2) begin : g_bad_sync $error("SYNC_STAGES must be >= 2"); end
  if (FILT_CYCLES < 1) begin : g_bad_filt $error("FILT_CYCLES must be >= 1"); end
  if (CNT_W < 1)       begin : g_bad_cntw $error("CNT_W must be >= 1");       end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    edgedet_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .async_level (i_level[c]),
      .rise_en     (i_rise_en[c]),
      .fall_en     (i_fall_en[c]),
      .clear       (i_clear[c]),
      .filt_level  (o_level[c]),
`ifdef EDGEDET_CNT_EN
      .count       (o_count[c*CNT_W +: CNT_W]),
`endif
      .tick        (o_tick[c]),
      .pending     (o_pending[c])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_irq <= 1'b0;
    else       o_irq <= |o_pending;
  end

endmodule

// File: tb/tb_edgedet_multi.sv
// Directed bench for edgedet_multi at default parameters: vector table for
// rise/fall/glitch/clear/irq, hand sequences for square wave, reset during a
// pending edge and (with EDGEDET_CNT_EN) counter saturation.
module tb_edgedet_multi;

  localparam int CH    = 4;
  localparam int CNT_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   i_level, i_rise_en, i_fall_en, i_clear;
  logic [CH-1:0]   o_level, o_tick, o_pending;
  logic            o_irq;
`ifdef EDGEDET_CNT_EN
  logic [CH*CNT_W-1:0] o_count;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  edgedet_multi #(.CH(CH), .SYNC_STAGES(2), .FILT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_level   (i_level),
    .i_rise_en (i_rise_en),
    .i_fall_en (i_fall_en),
    .i_clear   (i_clear),
    .o_level   (o_level),
    .o_tick    (o_tick),
    .o_pending (o_pending),
`ifdef EDGEDET_CNT_EN
    .o_count   (o_count),
`endif
    .o_irq     (o_irq)
  );

  typedef struct {
    logic [3:0] level, rise, fall, clr;
    logic [3:0] exp_level, exp_tick, exp_pend;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input logic [3:0] lv, input logic [3:0] cl,
                              input logic [3:0] el, input logic [3:0] et,
                              input logic [3:0] ep, input logic ei);
    vec_t v;
    v.level = lv; v.rise = 4'b0001; v.fall = 4'b0000; v.clr = cl;
    v.exp_level = el; v.exp_tick = et; v.exp_pend = ep; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Square-wave history for channel 2 (index < 0 reads as 0).
  logic sq_hist[80];
  function automatic logic h(input int k);
    return (k < 0) ? 1'b0 : sq_hist[k];
  endfunction

  initial begin
    // Glitch on ch1 (rows 1-2), ch0 rise/fall, clear-vs-tick collision.
    tbl[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[1]  = mk(4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[2]  = mk(4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[3]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[4]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[5]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tbl[6]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    tbl[7]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    tbl[8]  = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    for (int i = 9; i <= 13; i++)
      tbl[i] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tbl[14] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tbl[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tbl[16] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    tbl[17] = mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    for (int i = 18; i <= 22; i++)
      tbl[i] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tbl[23] = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    tbl[24] = mk(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    tbl[25] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    tbl[26] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    tbl[27] = mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Reset state
    reset = 1'b1;
    i_level = '0; i_rise_en = '0; i_fall_en = '0; i_clear = '0;
    repeat (3) tick_clk();
    chk("rst_level", 32'(o_level), 32'h0);
    chk("rst_tick", 32'(o_tick), 32'h0);
    chk("rst_pend", 32'(o_pending), 32'h0);
    chk("rst_irq", 32'(o_irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) tick_clk();

    // Table: inputs driven before edge i, outputs checked just after it.
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      i_level = tbl[i].level; i_rise_en = tbl[i].rise;
      i_fall_en = tbl[i].fall; i_clear = tbl[i].clr;
      tick_clk();
      chk($sformatf("tbl%0d_level", i), 32'(o_level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_tick", i), 32'(o_tick), 32'(tbl[i].exp_tick));
      chk($sformatf("tbl%0d_pend", i), 32'(o_pending), 32'(tbl[i].exp_pend));
      chk($sformatf("tbl%0d_irq", i), 32'(o_irq), 32'(tbl[i].exp_irq));
    end

    // Square wave on ch2, period 20, both edges enabled.
    begin
      int nticks = 0;
      @(negedge clk);
      i_rise_en = 4'b0100; i_fall_en = 4'b0100; i_clear = '0;
      for (int n = 0; n < 80; n++) begin
        sq_hist[n] = ((n / 10) % 2) == 1;
        @(negedge clk);
        i_level[2] = sq_hist[n];
        tick_clk();
        chk($sformatf("sq%0d_level", n), 32'(o_level[2]), 32'(h(n - 5)));
        chk($sformatf("sq%0d_tick", n), 32'(o_tick[2]), 32'(h(n - 6) ^ h(n - 7)));
        if (o_tick[2]) nticks++;
      end
      chk("sq_tick_count", 32'(nticks), 32'd7);
    end

    // Reset three edges into a pending ch3 rise, then release with level high.
    @(negedge clk);
    i_rise_en = 4'b1000; i_fall_en = '0; i_clear = 4'b1111; i_level = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    i_clear = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_level", 32'(o_level), 32'h0);
    chk("arst_tick", 32'(o_tick), 32'h0);
    chk("arst_pend", 32'(o_pending), 32'h0);
    chk("arst_irq", 32'(o_irq), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick_clk();
      chk($sformatf("inrst%0d_tick", k), 32'(o_tick), 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick_clk();
      chk($sformatf("rel%0d_tick", k), 32'(o_tick), (k == 7) ? 32'h8 : 32'h0);
    end
    chk("rel_pend", 32'(o_pending), 32'h8);
    tick_clk();
    chk("rel_irq", 32'(o_irq), 32'h1);

`ifdef EDGEDET_CNT_EN
    // Counter: 10 rises, then 290 more to saturate, clear, clear-with-tick.
    @(negedge clk);
    i_rise_en = 4'b0001; i_level = 4'b0000; i_clear = 4'b0001;
    @(negedge clk);
    i_clear = '0;
    for (int r = 0; r < 300; r++) begin
      @(negedge clk); i_level[0] = 1'b1;
      repeat (5) @(negedge clk);
      i_level[0] = 1'b0;
      repeat (4) @(negedge clk);
      if (r == 9) begin
        repeat (10) @(negedge clk);
        chk("cnt_10", 32'(o_count[7:0]), 32'd10);
      end
    end
    repeat (10) tick_clk();
    chk("cnt_sat", 32'(o_count[7:0]), 32'd255);
    @(negedge clk); i_clear = 4'b0001;
    tick_clk();
    chk("cnt_clr", 32'(o_count[7:0]), 32'd0);
    @(negedge clk); i_clear = '0; i_level[0] = 1'b1;
    begin
      int k = 0;
      tick_clk();
      while (!o_tick[0] && k < 20) begin
        tick_clk();
        k++;
      end
      chk("cnt_tick_seen", 32'(o_tick[0]), 32'h1);
    end
    @(negedge clk); i_clear = 4'b0001;
    tick_clk();
    chk("cnt_clr_tick", 32'(o_count[7:0]), 32'd1);
    @(negedge clk); i_clear = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/edgedet_multi.md
Name: edgedet_multi

Overview:
Multi-channel, parametrised edge detector with Moore-style output; successor to the single-channel level-to-tick detector.
Each channel has:
- a synchroniser chain
- a glitch filter
- a four-state Moore FSM that emits one-cycle ticks on rising and/or falling edges, enabled per channel at run time

Sticky pending flags with clear and an OR-reduced interrupt allow direct use as a GPIO/button event front end on the peripheral bus.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_CYCLES, 4, consecutive cycles the synchronised input must differ from the filtered level before the filtered level toggles (>=1)
CNT_W, 8, edge-counter width (used only with EDGEDET_CNT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_level  in  CH  asynchronous level inputs
i_rise_en  in  CH  per-channel rising-edge tick enable
i_fall_en  in  CH  per-channel falling-edge tick enable
i_clear  in  CH  per-channel clear of pending flag (and counter)
o_level  out  CH  filtered level
o_tick  out  CH  one-cycle edge pulse
o_pending  out  CH  sticky event flag
o_irq  out  1  OR of o_pending
o_count  out  CH*CNT_W  per-channel edge count, channel c at [c*CNT_W +: CNT_W] (only with EDGEDET_CNT_EN)

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk. All of the following clear to 0 during reset: sync flops, filter counters, o_level, o_tick, o_pending, o_irq, o_count; FSMs go to ST_ZERO.
- Synchroniser: synchroniser output s reflects i_level after SYNC_STAGES edges.
- Filter counter: counts edges where s != o_level; it resets to 0 on any edge where s == o_level.
- Filter toggle: on the FILT_CYCLES-th consecutive differing edge, o_level toggles and the counter clears.
- Glitch rejection: pulses at s shorter than FILT_CYCLES cycles are discarded.
- FSM states are ST_ZERO, ST_RISE, ST_ONE and ST_FALL; the FSM reads the registered o_level:
  - ST_ZERO: go to ST_RISE if o_level = 1.
  - ST_RISE: go to ST_ONE if o_level = 1, else ST_FALL.
  - ST_ONE: go to ST_FALL if o_level = 0.
  - ST_FALL: go to ST_RISE if o_level = 1, else ST_ZERO.
  - Default: ST_ZERO.
- o_tick (Moore, decoded from state only) = (ST_RISE & i_rise_en) | (ST_FALL & i_fall_en).
- Edge latency: stable input change to o_tick is L = SYNC_STAGES + FILT_CYCLES + 1 edges (7 at defaults). o_tick is high for exactly one cycle.
- Pending flags: o_pending[c] sets on o_tick[c] and clears on i_clear[c]. If both occur in the same cycle, set wins. o_irq is the registered OR of o_pending.
- Enable changes take effect combinationally on o_tick; they never alter the FSM state.
- Level high at reset release: the filter treats it as a 0->1 change, so a rising tick fires L edges after release if enabled.
- Channels are fully independent; simultaneous events on several channels are all reported.

Optional Feature:
Macro EDGEDET_CNT_EN.
- Defined: o_count exists. Each channel has a CNT_W-bit counter that increments on o_tick and saturates at all-ones. i_clear[c] zeroes it; clear and tick in the same cycle gives 1.
- Undefined: the o_count port and the counters are absent; all other behaviour is identical.

Decomposition:
- Package edgedet_pkg holds:
  - typedef enum logic [1:0] edge_state_t {ST_ZERO, ST_RISE, ST_ONE, ST_FALL}
  - default parameter constants
- Sub-module edgedet_chan holds one channel's synchroniser, filter, FSM, pending flag and optional counter.
- edgedet_multi instantiates CH copies of edgedet_chan in a generate loop and ORs the pending flags.

Test Plan:
1. Channel 0 rise_en=1, fall_en=0; i_level[0] 0->1 held 20 cycles, then 1->0 -> one o_tick[0] exactly 7 edges after change; no tick on fall; o_pending[0]=1, o_irq=1.
2. i_level[1] high for 2 cycles only -> o_level[1], o_tick[1] and o_pending[1] stay 0.
3. Channel 2 both enables set; square wave, period 20 -> one tick every 10 cycles, o_level[2] tracking the input delayed by 6 edges.
4. i_clear[0] in the same cycle as o_tick[0] -> o_pending[0] stays 1; i_clear[0] on the next cycle -> o_pending[0]=0, o_irq=0.
5. Reset asserted 3 edges after i_level[3] rises -> all outputs 0 immediately; no tick during reset. Level held high, reset released -> rising tick 7 edges after release.
6. EDGEDET_CNT_EN defined, CNT_W=8; 300 rising edges on channel 0 -> o_count[7:0]=255 (saturated); then i_clear[0] -> 0.
